// File: rtl/dcache_pkg.sv
// Shared definitions for the set-associative data cache: FSM states,
// address-split width helpers and line word selection.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_e;

  // Widest line the word-select helper accepts; narrower lines are zero-extended.
  localparam int MAX_LINE_W = 1024;

  function automatic int off_w(input int line_w);
    return $clog2(line_w / 8);
  endfunction

  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(input int line_w, input int sets);
    return 32 - off_w(line_w) - idx_w(sets);
  endfunction

  function automatic int sel_w(input int line_w);
    return (line_w > 32) ? $clog2(line_w / 32) : 1;
  endfunction

  function automatic logic [31:0] word_sel(input logic [MAX_LINE_W-1:0] line,
                                           input int unsigned           w);
    logic [MAX_LINE_W-1:0] shifted;
    shifted = line >> (w * 32);
    return shifted[31:0];
  endfunction

endpackage

// File: rtl/dcache_way.sv
// One cache way: per-set tag, valid, dirty and line storage with a combinational
// lookup on idx; line fills and word stores commit on the rising clock edge.
module dcache_way #(
  parameter int SETS   = 16,
  parameter int LINE_W = 256,
  parameter int IDX_W  = 4,
  parameter int TAG_W  = 23,
  parameter int SEL_W  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDX_W-1:0]  idx,
  output logic              valid,
  output logic              dirty,
  output logic [TAG_W-1:0]  tag,
  output logic [LINE_W-1:0] line,
  input  logic              fill_en,
  input  logic [TAG_W-1:0]  fill_tag,
  input  logic [LINE_W-1:0] fill_line,
  input  logic              store_en,
  input  logic [SEL_W-1:0]  store_sel,
  input  logic [31:0]       store_word
);

  logic [SETS-1:0]   valid_q;
  logic [SETS-1:0]   dirty_q;
  logic [TAG_W-1:0]  tag_q  [SETS];
  logic [LINE_W-1:0] line_q [SETS];

  assign valid = valid_q[idx];
  assign dirty = dirty_q[idx];
  assign tag   = tag_q[idx];
  assign line  = line_q[idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_en) begin
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= 1'b0;
    end else if (store_en) begin
      dirty_q[idx] <= 1'b1;
    end
  end

  // Tag and data arrays carry no reset; valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[idx]  <= fill_tag;
      line_q[idx] <= fill_line;
    end else if (store_en) begin
      line_q[idx][{store_sel, 5'b0} +: 32] <= store_word;
    end
  end

endmodule

// File: rtl/dcache_assoc.sv
// Write-back, write-allocate set-associative data cache; hits answer in the same cycle,
// misses stall through WRITEBACK/ALLOCATE. DCACHE_PERF_CNT_EN adds hit/miss counters.
module dcache_assoc
  import dcache_pkg::*;
#(
  parameter int WAYS   = 2,
  parameter int SETS   = 16,
  parameter int LINE_W = 256
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       addr_i,
  input  logic [31:0]       write_data_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  output logic [31:0]       data_o,
  output logic              stall_o,
  output logic [31:0]       mem_addr_o,
  output logic [LINE_W-1:0] mem_write_data_o,
  output logic              mem_MemRead_o,
  output logic              mem_MemWrite_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i
`ifdef DCACHE_PERF_CNT_EN
  ,
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o
`endif
);

  localparam int OFF_W = off_w(LINE_W);
  localparam int IDX_W = idx_w(SETS);
  localparam int TAG_W = tag_w(LINE_W, SETS);
  localparam int SEL_W = sel_w(LINE_W);
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx, miss_idx_q;
  logic [TAG_W-1:0]  req_tag, miss_tag_q;
  logic [WAY_W-1:0]  victim, victim_q;
  logic [WAY_W-1:0]  rr_q [SETS];
  logic [SEL_W-1:0]  sel;
  logic              req, store, load, hit, miss, fill, store_hit, free_found;
  logic [WAYS-1:0]   way_valid, way_dirty, way_hit;
  logic [TAG_W-1:0]  way_tag  [WAYS];
  logic [LINE_W-1:0] way_line [WAYS];
  logic [LINE_W-1:0] hit_line;
  logic              unused_ok;

  assign req       = MemRead_i | MemWrite_i;
  assign store     = MemWrite_i;
  assign load      = MemRead_i & ~MemWrite_i;
  assign req_tag   = addr_i[31 -: TAG_W];
  assign sel       = SEL_W'(addr_i[OFF_W-1:0] >> 2);
  assign unused_ok = ^addr_i[1:0];
  // Outside IDLE the arrays are steered to the set of the outstanding miss.
  assign idx       = (state_q == IDLE) ? addr_i[OFF_W +: IDX_W] : miss_idx_q;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    dcache_way #(
      .SETS(SETS), .LINE_W(LINE_W), .IDX_W(IDX_W), .TAG_W(TAG_W), .SEL_W(SEL_W)
    ) u_way (
      .clk        (clk_i),
      .rst_n      (rst_i),
      .idx        (idx),
      .valid      (way_valid[w]),
      .dirty      (way_dirty[w]),
      .tag        (way_tag[w]),
      .line       (way_line[w]),
      .fill_en    (fill && (victim_q == WAY_W'(w))),
      .fill_tag   (miss_tag_q),
      .fill_line  (mem_data_i),
      .store_en   (store_hit && way_hit[w]),
      .store_sel  (sel),
      .store_word (write_data_i)
    );
    assign way_hit[w] = way_valid[w] && (way_tag[w] == req_tag);
  end

  assign hit = |way_hit;

  always_comb begin
    hit_line   = '0;
    victim     = rr_q[idx];
    free_found = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (way_hit[w]) hit_line = way_line[w];
      if (!way_valid[w] && !free_found) begin
        victim     = WAY_W'(w);
        free_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d          = state_q;
    miss             = 1'b0;
    fill             = 1'b0;
    store_hit        = 1'b0;
    stall_o          = 1'b0;
    data_o           = '0;
    mem_MemRead_o    = 1'b0;
    mem_MemWrite_o   = 1'b0;
    mem_addr_o       = '0;
    mem_write_data_o = '0;
    case (state_q)
      IDLE: begin
        if (rst_i && req) begin
          if (hit) begin
            store_hit = store;
            if (load) data_o = word_sel(MAX_LINE_W'(hit_line), 32'(sel));
          end else begin
            miss    = 1'b1;
            stall_o = 1'b1;
            state_d = (way_valid[victim] && way_dirty[victim]) ? WRITEBACK : ALLOCATE;
          end
        end
      end
      WRITEBACK: begin
        stall_o          = 1'b1;
        mem_MemWrite_o   = 1'b1;
        mem_addr_o       = {way_tag[victim_q], miss_idx_q, {OFF_W{1'b0}}};
        mem_write_data_o = way_line[victim_q];
        if (mem_ack_i) state_d = ALLOCATE;
      end
      ALLOCATE: begin
        stall_o       = 1'b1;
        mem_MemRead_o = 1'b1;
        mem_addr_o    = {miss_tag_q, miss_idx_q, {OFF_W{1'b0}}};
        if (mem_ack_i) begin
          fill    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      miss_idx_q <= '0;
      miss_tag_q <= '0;
      victim_q   <= '0;
      for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
    end else begin
      state_q <= state_d;
      if (miss) begin
        miss_idx_q <= idx;
        miss_tag_q <= req_tag;
        victim_q   <= victim;
      end
      if (fill) begin
        rr_q[miss_idx_q] <= (rr_q[miss_idx_q] == WAY_W'(WAYS - 1)) ? '0
                                                                   : rr_q[miss_idx_q] + 1'b1;
      end
    end
  end

`ifdef DCACHE_PERF_CNT_EN
  // retry_q marks the replay of a request that already missed, so it is not a hit.
  logic retry_q;
  logic first_hit;

  assign first_hit = (state_q == IDLE) && rst_i && req && hit && !retry_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      retry_q    <= 1'b0;
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else begin
      if (miss) retry_q <= 1'b1;
      else if ((state_q == IDLE) && req && hit) retry_q <= 1'b0;
      if (miss && (miss_cnt_o != '1)) miss_cnt_o <= miss_cnt_o + 32'd1;
      if (first_hit && (hit_cnt_o != '1)) hit_cnt_o <= hit_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_assoc.sv
// Scoreboard bench for dcache_assoc: directed accesses push expected results,
// a negedge monitor pops and compares on completions and memory acks.
module tb_dcache_assoc;

  localparam int LINE_W   = 256;
  localparam int FILL_LAT = 3;
  localparam int WB_LAT   = 2;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [31:0]       addr_i, write_data_i;
  logic              MemRead_i, MemWrite_i;
  logic [31:0]       data_o;
  logic              stall_o;
  logic [31:0]       mem_addr_o;
  logic [LINE_W-1:0] mem_write_data_o;
  logic              mem_MemRead_o, mem_MemWrite_o;
  logic [LINE_W-1:0] mem_data_i;
  logic              mem_ack_i;
`ifdef DCACHE_PERF_CNT_EN
  logic [31:0]       hit_cnt_o, miss_cnt_o;
`endif

  dcache_assoc #(.WAYS(2), .SETS(16), .LINE_W(LINE_W)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .addr_i           (addr_i),
    .write_data_i     (write_data_i),
    .MemRead_i        (MemRead_i),
    .MemWrite_i       (MemWrite_i),
    .data_o           (data_o),
    .stall_o          (stall_o),
    .mem_addr_o       (mem_addr_o),
    .mem_write_data_o (mem_write_data_o),
    .mem_MemRead_o    (mem_MemRead_o),
    .mem_MemWrite_o   (mem_MemWrite_o),
    .mem_data_i       (mem_data_i),
    .mem_ack_i        (mem_ack_i)
`ifdef DCACHE_PERF_CNT_EN
    ,
    .hit_cnt_o        (hit_cnt_o),
    .miss_cnt_o       (miss_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit          load;
    logic [31:0] data;
    int          stalls;
  } exp_t;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
  } mexp_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  bit   mon_off  = 1'b1;
  int   stall_run = 0;
  int   resp_cnt  = 0;
  exp_t  exp_q [$];
  mexp_t mem_q [$];
  exp_t  mon_e;
  mexp_t mon_m;
  logic [LINE_W-1:0] mem_lines [logic [31:0]];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Untouched memory holds (byte address of word) ^ 0x5A5A0000 in every word.
  function automatic logic [LINE_W-1:0] line_of(input logic [31:0] la);
    logic [LINE_W-1:0] l;
    if (mem_lines.exists(la)) return mem_lines[la];
    for (int w = 0; w < LINE_W / 32; w++) l[w*32 +: 32] = (la + 32'(4 * w)) ^ 32'h5A5A_0000;
    return l;
  endfunction

  // Memory responder: ack on the N-th cycle a request is held.
  initial begin
    mem_ack_i  = 1'b0;
    mem_data_i = '0;
    forever begin
      @(posedge clk_i); #1;
      mem_ack_i = 1'b0;
      if (rst_i && (mem_MemRead_o || mem_MemWrite_o)) begin
        resp_cnt++;
        if (resp_cnt == (mem_MemWrite_o ? WB_LAT : FILL_LAT)) begin
          resp_cnt  = 0;
          mem_ack_i = 1'b1;
          if (mem_MemWrite_o) mem_lines[mem_addr_o] = mem_write_data_o;
          else mem_data_i = line_of(mem_addr_o);
        end
      end else begin
        resp_cnt = 0;
      end
    end
  end

  always @(negedge clk_i) begin
    if (mon_off || !rst_i) begin
      stall_run = 0;
    end else if (MemRead_i || MemWrite_i) begin
      if (stall_o) begin
        stall_run++;
      end else if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected completion: addr 0x%08h, got no expectation, expected none", addr_i);
      end else begin
        mon_e = exp_q.pop_front();
        check("stall cycles", 32'(stall_run), 32'(mon_e.stalls));
        check(mon_e.load ? "load data" : "store data_o", data_o, mon_e.load ? mon_e.data : 32'h0);
        stall_run = 0;
      end
    end else begin
      check("idle stall_o", {31'b0, stall_o}, 32'h0);
      check("idle data_o", data_o, 32'h0);
    end
    if (mem_ack_i && rst_i) begin
      if (mem_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected mem burst: addr 0x%08h, expected none", mem_addr_o);
      end else begin
        mon_m = mem_q.pop_front();
        check(mon_m.wr ? "writeback addr" : "fill addr", mem_addr_o, mon_m.addr);
        check("mem write strobe", {31'b0, mem_MemWrite_o}, {31'b0, mon_m.wr});
        check("mem read strobe", {31'b0, mem_MemRead_o}, {31'b0, !mon_m.wr});
      end
    end
  end

  task automatic expect_mem(input bit wr, input logic [31:0] a);
    mexp_t m;
    m.wr   = wr;
    m.addr = a;
    mem_q.push_back(m);
  endtask

  task automatic access(input bit st, input bit both, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] ed, input int stalls);
    exp_t e;
    int   n;
    e.load   = !st;
    e.data   = ed;
    e.stalls = stalls;
    exp_q.push_back(e);
    addr_i       = a;
    write_data_i = wd;
    MemWrite_i   = st;
    MemRead_i    = !st || both;
    n = 0;
    @(negedge clk_i);
    while (stall_o && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    if (stall_o) begin
      n_checks++;
      n_fail++;
      $display("FAIL access timeout: addr 0x%08h stalled %0d cycles, expected %0d", a, n, stalls);
    end
    @(posedge clk_i); #1;
    MemRead_i  = 1'b0;
    MemWrite_i = 1'b0;
  endtask

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation time exhausted, expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1);
  end

  initial begin
    rst_i        = 1'b0;
    addr_i       = 32'h100;
    write_data_i = '0;
    MemRead_i    = 1'b1;
    MemWrite_i   = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("reset stall_o", {31'b0, stall_o}, 32'h0);
    check("reset data_o", data_o, 32'h0);
    check("reset mem read", {31'b0, mem_MemRead_o}, 32'h0);
    check("reset mem write", {31'b0, mem_MemWrite_o}, 32'h0);
    MemRead_i = 1'b0;
    @(posedge clk_i); #1;
    rst_i   = 1'b1;
    mon_off = 1'b0;

    expect_mem(0, 32'h100);
    access(0, 0, 32'h100, 32'h0, 32'h5A5A_0100, 4);
    access(1, 0, 32'h104, 32'hDEAD_BEEF, 32'h0, 0);
    access(0, 0, 32'h104, 32'h0, 32'hDEAD_BEEF, 0);
    access(0, 0, 32'h11C, 32'h0, 32'h5A5A_011C, 0);
    access(1, 1, 32'h108, 32'h1234_5678, 32'h0, 0);
    access(0, 0, 32'h108, 32'h0, 32'h1234_5678, 0);
    expect_mem(0, 32'h300);
    access(0, 0, 32'h300, 32'h0, 32'h5A5A_0300, 4);
    expect_mem(1, 32'h100);
    expect_mem(0, 32'h500);
    access(0, 0, 32'h500, 32'h0, 32'h5A5A_0500, 1 + WB_LAT + FILL_LAT);
    expect_mem(0, 32'h100);
    access(0, 0, 32'h104, 32'h0, 32'hDEAD_BEEF, 4);
    access(0, 0, 32'h500, 32'h0, 32'h5A5A_0500, 0);
    expect_mem(0, 32'h640);
    access(1, 0, 32'h640, 32'hCAFE_F00D, 32'h0, 4);
    access(0, 0, 32'h640, 32'h0, 32'hCAFE_F00D, 0);

    // Reset lands while the fill for 0x700 is outstanding.
    mon_off   = 1'b1;
    addr_i    = 32'h700;
    MemRead_i = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    check("fill before reset", {31'b0, mem_MemRead_o}, 32'h1);
    #1 rst_i = 1'b0;
    #1;
    check("mid-fill reset mem read", {31'b0, mem_MemRead_o}, 32'h0);
    check("mid-fill reset stall_o", {31'b0, stall_o}, 32'h0);
    check("mid-fill reset data_o", data_o, 32'h0);
    MemRead_i = 1'b0;
    @(posedge clk_i); #1;
    rst_i   = 1'b1;
    mon_off = 1'b0;

    expect_mem(0, 32'h100);
    access(0, 0, 32'h100, 32'h0, 32'h5A5A_0100, 4);
    access(0, 0, 32'h104, 32'h0, 32'hDEAD_BEEF, 0);
    access(0, 0, 32'h108, 32'h0, 32'h1234_5678, 0);
    access(0, 0, 32'h11C, 32'h0, 32'h5A5A_011C, 0);
`ifdef DCACHE_PERF_CNT_EN
    check("miss_cnt", miss_cnt_o, 32'd1);
    check("hit_cnt", hit_cnt_o, 32'd3);
`endif

    repeat (3) @(negedge clk_i);
    check("access queue drained", 32'(exp_q.size()), 32'h0);
    check("mem queue drained", 32'(mem_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
